// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// bus_arbiter_pkg : shared FSM/owner types and grant-vector helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_IFU = 0;
    localparam int unsigned GNT_LSU = 1;

    function automatic arb_owner_t gnt_to_owner(input logic [1:0] gnt);
        return gnt[GNT_LSU] ? OWN_LSU : OWN_IFU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_if.sv
// ============================================================================
// bus_arbiter_if : fetch, load/store and shared-memory handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface bus_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             ifu_req_valid;
    logic             ifu_req_ready;
    logic [WIDTH-1:0] ifu_req_addr;
    logic             ifu_rsp_valid;
    logic [WIDTH-1:0] ifu_rsp_data;

    logic             lsu_req_valid;
    logic             lsu_req_ready;
    logic [WIDTH-1:0] lsu_req_addr;
    logic             lsu_req_wen;
    logic [WIDTH-1:0] lsu_req_wdata;
    logic             lsu_rsp_valid;
    logic [WIDTH-1:0] lsu_rsp_data;

    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [WIDTH-1:0] mem_req_addr;
    logic             mem_req_wen;
    logic [WIDTH-1:0] mem_req_wdata;
    logic             mem_rsp_valid;
    logic [WIDTH-1:0] mem_rsp_data;

    // Arbiter side
    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    // Environment side: the two requesters plus the memory
    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

endinterface

`default_nettype wire

// File: rtl/bus_arbiter_grant.sv
// ============================================================================
// arb_grant : two-way grant select; LSU priority, or alternate when
//             ARB_ROUND_ROBIN_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module arb_grant
    import bus_arbiter_pkg::*;
(
    input  logic       req_ifu_i,
    input  logic       req_lsu_i,
    input  arb_owner_t last_owner_i,
    output logic [1:0] gnt_o
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic c_RR_EN = 1'b1;
`else
    localparam logic c_RR_EN = 1'b0;
`endif

    always_comb begin
        gnt_o = 2'b00;
        if (req_ifu_i && req_lsu_i) begin
            // On contention the IFU only wins when alternating and LSU went last
            if (c_RR_EN && (last_owner_i == OWN_LSU)) begin
                gnt_o[GNT_IFU] = 1'b1;
            end else begin
                gnt_o[GNT_LSU] = 1'b1;
            end
        end else if (req_lsu_i) begin
            gnt_o[GNT_LSU] = 1'b1;
        end else if (req_ifu_i) begin
            gnt_o[GNT_IFU] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : shares one memory port between fetch and load/store units,
//               one transaction in flight. Option: ARB_ROUND_ROBIN_EN. Rev 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_arbiter_if.slave bus,
    output logic         busy_o
);

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    logic [WIDTH-1:0] addr_q,  addr_d;
    logic             wen_q,   wen_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]       w_gnt;

    arb_grant u_grant (
        .req_ifu_i    (bus.ifu_req_valid),
        .req_lsu_i    (bus.lsu_req_valid),
        .last_owner_i (owner_q),
        .gnt_o        (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (|w_gnt) begin
                    owner_d = gnt_to_owner(w_gnt);
                    state_d = REQ;
                    if (w_gnt[GNT_LSU]) begin
                        addr_d  = bus.lsu_req_addr;
                        wen_d   = bus.lsu_req_wen;
                        wdata_d = bus.lsu_req_wdata;
                    end else begin
                        addr_d  = bus.ifu_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (bus.mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so a held request is never acknowledged in reset
    always_comb begin
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = addr_q;
        bus.mem_req_wen   = wen_q;
        bus.mem_req_wdata = wdata_q;
        bus.ifu_rsp_data  = bus.mem_rsp_data;
        bus.lsu_rsp_data  = bus.mem_rsp_data;
        busy_o            = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                bus.ifu_req_ready = w_gnt[GNT_IFU] & rst_n;
                bus.lsu_req_ready = w_gnt[GNT_LSU] & rst_n;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
            end
            RSP: begin
                bus.ifu_rsp_valid = bus.mem_rsp_valid & (owner_q == OWN_IFU);
                bus.lsu_rsp_valid = bus.mem_rsp_valid & (owner_q == OWN_LSU);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// tb_bus_arbiter : randomized bench with transaction-timeline model and
//                  response scoreboard. Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    bus_arbiter_if #(.WIDTH(W)) bus ();

    bus_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           lsu;
        bit           store;
        logic [W-1:0] data;
        int           at;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;

    // Timeline of the transaction in flight, in cycle numbers
    bit           txn;
    int           t_grant, accept_at, rsp_at, free_at;
    bit           last_lsu;
    logic [W-1:0] m_addr, m_wdata, m_rdata;
    bit           m_wen;

    bit           p_ifu, p_lsu, lsu_w;
    logic [W-1:0] ifu_a, lsu_a, lsu_d;
    bit           rst_prev;
    int           n_resets;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit allow_new, input bit allow_rst);
        bit v_ifu, v_lsu, g_ifu, g_lsu, in_rst, force_rsp, exp_mv;
        int d, r;
        @(posedge clk);
        #1;
        in_rst = 1'b0;
        if (cyc < 3) begin
            in_rst = 1'b1;
        end else if (allow_rst && n_resets < 20 && txn && cyc > accept_at && cyc <= rsp_at
                     && $urandom_range(0, 9) == 0) begin
            in_rst = 1'b1;
        end
        force_rsp = rst_prev && !in_rst;
        rst_prev  = in_rst;
        rst_n     = !in_rst;
        if (in_rst) begin
            txn      = 1'b0;
            free_at  = 0;
            last_lsu = 1'b0;
            exp_q.delete();
            if (cyc >= 3) n_resets++;
        end

        if (allow_new && !p_ifu && $urandom_range(0, 2) == 0) begin
            p_ifu = 1'b1;
            ifu_a = $urandom;
        end
        if (allow_new && !p_lsu && $urandom_range(0, 2) == 0) begin
            p_lsu = 1'b1;
            lsu_a = $urandom;
            lsu_d = $urandom;
            lsu_w = 1'($urandom_range(0, 1));
        end
        v_ifu = allow_new && p_ifu && ($urandom_range(0, 3) != 0);
        v_lsu = allow_new && p_lsu && ($urandom_range(0, 3) != 0);
        bus.ifu_req_valid = v_ifu;
        bus.ifu_req_addr  = p_ifu ? ifu_a : $urandom;
        bus.lsu_req_valid = v_lsu;
        bus.lsu_req_addr  = p_lsu ? lsu_a : $urandom;
        bus.lsu_req_wen   = p_lsu ? lsu_w : 1'($urandom_range(0, 1));
        bus.lsu_req_wdata = p_lsu ? lsu_d : $urandom;

        bus.mem_rsp_data = $urandom;
        if (txn && cyc > t_grant && cyc < accept_at)  bus.mem_req_ready = 1'b0;
        else if (txn && cyc == accept_at)             bus.mem_req_ready = 1'b1;
        else                                          bus.mem_req_ready = 1'($urandom_range(0, 1));
        if (force_rsp) begin
            bus.mem_rsp_valid = 1'b1;
        end else if (txn && cyc == rsp_at) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = m_rdata;
        end else if (txn && cyc > accept_at && cyc < rsp_at) begin
            bus.mem_rsp_valid = 1'b0;
        end else begin
            bus.mem_rsp_valid = ($urandom_range(0, 4) == 0);
        end

        g_ifu = 1'b0;
        g_lsu = 1'b0;
        if (!in_rst && cyc >= free_at && (v_ifu || v_lsu)) begin
            if (v_ifu && v_lsu) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_lsu) g_ifu = 1'b1;
                else          g_lsu = 1'b1;
`else
                g_lsu = 1'b1;
`endif
            end else if (v_lsu) begin
                g_lsu = 1'b1;
            end else begin
                g_ifu = 1'b1;
            end
        end

        @(negedge clk);
        check1("ifu_req_ready", bus.ifu_req_ready, g_ifu);
        check1("lsu_req_ready", bus.lsu_req_ready, g_lsu);
        check1("busy", busy, !in_rst && txn && cyc > t_grant && cyc <= rsp_at);
        exp_mv = !in_rst && txn && cyc > t_grant && cyc <= accept_at;
        check1("mem_req_valid", bus.mem_req_valid, exp_mv);
        if (exp_mv) begin
            check32("mem_req_addr", bus.mem_req_addr, m_addr);
            check1("mem_req_wen", bus.mem_req_wen, m_wen);
            if (m_wen) check32("mem_req_wdata", bus.mem_req_wdata, m_wdata);
        end
        if (in_rst) check32("payload_in_reset", bus.mem_req_addr, '0);

        if (g_ifu || g_lsu) begin
            d         = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
            r         = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            t_grant   = cyc;
            accept_at = cyc + 1 + d;
            rsp_at    = accept_at + 1 + r;
            free_at   = rsp_at + 1;
            txn       = 1'b1;
            last_lsu  = g_lsu;
            m_wen     = g_lsu && lsu_w;
            m_addr    = g_lsu ? lsu_a : ifu_a;
            m_wdata   = lsu_d;
            m_rdata   = $urandom;
            exp_q.push_back('{lsu: g_lsu, store: m_wen, data: m_rdata, at: rsp_at});
            if (g_lsu) p_lsu = 1'b0;
            else       p_ifu = 1'b0;
        end
    endtask

    // Response monitor: every rsp pulse must match the oldest expectation
    always @(negedge clk) begin
        if (bus.ifu_rsp_valid === 1'b1 || bus.lsu_rsp_valid === 1'b1) begin
            if (bus.ifu_rsp_valid === 1'b1 && bus.lsu_rsp_valid === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL rsp_both cyc=%0d actual=ifu:1,lsu:1 required=one", cyc);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected cyc=%0d actual=ifu:%b,lsu:%b required=none",
                         cyc, bus.ifu_rsp_valid, bus.lsu_rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check1("rsp_owner_lsu", bus.lsu_rsp_valid, mon_e.lsu);
                check32("rsp_cycle", cyc, mon_e.at);
                if (!mon_e.store) begin
                    check32("rsp_data", mon_e.lsu ? bus.lsu_rsp_data : bus.ifu_rsp_data,
                            mon_e.data);
                end
            end
        end
    end

    initial begin
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_addr  = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = '0;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_wdata = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        for (int i = 0; i < 3000; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 40; i++)   step(1'b0, 1'b0);
        check32("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
